// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a shared memory port.
// Define MEM_ARB_BURST_LOCK_EN to hold a grant across a burst (until last or MAX_BEATS beats).
module mem_port_arbiter #(
  parameter int MAX_BEATS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_valid,
  input  logic [3:0] req_last,
  output logic [3:0] req_ready,
  output logic       mem_valid,
  input  logic       mem_ready,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick_idx;
  logic             pick_found;
  logic             beat;
  logic             release_now;
  logic [CNT_W-1:0] cnt_next;

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    pick_idx   = ptr;
    pick_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[ptr + 2'(i)]) begin
        pick_idx   = ptr + 2'(i);
        pick_found = 1'b1;
      end
    end
  end

  assign busy      = (state == BUSY);
  assign mem_valid = busy && req_valid[sel];
  assign beat      = mem_valid && mem_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign req_ready[gi] = busy && (sel == 2'(gi)) && mem_ready;
  end

`ifdef MEM_ARB_BURST_LOCK_EN
  assign release_now = req_last[sel] || (cnt == CNT_W'(MAX_BEATS - 1));
  assign cnt_next    = cnt + 1'b1;
`else
  // Without locking every beat ends the grant and the beat counter never moves.
  logic unused_inputs;
  assign unused_inputs = ^{req_last, cnt};
  assign release_now   = 1'b1;
  assign cnt_next      = cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= BUSY;
            grant <= 4'b0001 << pick_idx;
            sel   <= pick_idx;
            cnt   <= '0;
          end else begin
            grant <= 4'b0000;
          end
        end
        BUSY: begin
          if (beat) begin
            cnt <= cnt_next;
            if (release_now) begin
              state <= IDLE;
              grant <= 4'b0000;
              ptr   <= sel + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX_BEATS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_valid = 4'b0000;
  logic [3:0] req_last = 4'b0000;
  logic [3:0] req_ready;
  logic       mem_valid;
  logic       mem_ready = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .sel(sel), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the port, how many beats it has moved, where the scan starts.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_beats;
  bit m_found;
  bit m_done;
  int m_cand;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_busy) begin
      m_found = 0;
      for (int k = 0; k < 4; k++) begin
        m_cand = (m_ptr + k) % 4;
        if (!m_found && req_valid[m_cand]) begin
          m_found = 1;
          m_owner = m_cand;
        end
      end
      if (m_found) begin
        m_busy = 1;
        m_beats = 0;
      end
    end else if (req_valid[m_owner] && mem_ready) begin
      m_beats = m_beats + 1;
`ifdef MEM_ARB_BURST_LOCK_EN
      m_done = req_last[m_owner] || (m_beats == MAX_BEATS);
`else
      m_done = 1;
`endif
      $display("beat owner=%0d beats=%0d release=%0d", m_owner, m_beats, m_done);
      if (m_done) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % 4;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    req_last = 4'b0000;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({grant, busy, sel, mem_valid, req_ready} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: grant=%b busy=%b sel=%0d mem_valid=%b req_ready=%b, want all 0",
               grant, busy, sel, mem_valid, req_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b sel=%0d busy=%b, want 0100 2 1", grant, sel, busy);
    end
    checks++;
    if (req_ready !== 4'b0100 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_handshake: req_ready=%b mem_valid=%b, want 0100 1", req_ready, mem_valid);
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b sel=%0d, want 0000 0 2", grant, busy, sel);
    end
    $display("test_single done");
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    logic [3:0] one;
    one = 4'b0001;
    do_reset();
    @(negedge clk);
    req_valid = 4'b1111;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      exp_g = (k % 2 == 0) ? (one << ((k / 2) % 4)) : 4'b0000;
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL fairness_cycle%0d: grant=%b, want %b", k, grant, exp_g);
      end
    end
    req_valid = 4'b0000;
    $display("test_fairness done");
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010;
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (grant !== 4'b0010 || req_ready !== 4'b0000 || mem_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: grant=%b req_ready=%b mem_valid=%b, want 0010 0000 1",
                 k, grant, req_ready, mem_valid);
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL backpressure_ready: req_ready=%b, want 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: grant=%b busy=%b, want 0000 0", grant, busy);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010;
    mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_pre: grant=%b, want 0010", grant);
    end
    mem_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || mem_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: grant=%b mem_valid=%b req_ready=%b busy=%b, want all 0",
               grant, mem_valid, req_ready, busy);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL midreset_idle%0d: busy=%b grant=%b, want 0 0000", k, busy, grant);
      end
    end
    $display("test_reset_mid_burst done");
  endtask

`ifdef MEM_ARB_BURST_LOCK_EN
  task automatic test_lock_burst();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_last = 4'b0001;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL lock_setup: grant=%b, want 0001", grant);
    end
    req_valid = 4'b1011;
    req_last = 4'b1001;
    @(negedge clk); #1;
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk); #1;
      checks++;
      if (grant !== 4'b0010) begin
        errors++;
        $display("FAIL lock_beat%0d: grant=%b, want 0010", b, grant);
      end
      if (b == 3) req_last = 4'b1011;
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_gap: busy=%b, want 0", busy);
    end
    req_valid = 4'b1001;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL lock_next3: grant=%b, want 1000", grant);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL lock_next0: grant=%b, want 0001", grant);
    end
    req_valid = 4'b0000;
    $display("test_lock_burst done");
  endtask

  task automatic test_lock_max_beats();
    do_reset();
    @(negedge clk);
    req_valid = 4'b1000;
    req_last = 4'b0000;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    req_valid = 4'b1001;
    for (int b = 1; b <= MAX_BEATS; b++) begin
      checks++;
      if (grant !== 4'b1000) begin
        errors++;
        $display("FAIL maxbeats_beat%0d: grant=%b, want 1000", b, grant);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL maxbeats_release: busy=%b, want 0", busy);
    end
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL maxbeats_next: grant=%b, want 0001", grant);
    end
    req_valid = 4'b0000;
    $display("test_lock_max_beats done");
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_grant;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_sel;
    logic [3:0] one;
    one = 4'b0001;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom_range(0, 15));
      req_last = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_grant = m_busy ? (one << m_owner) : 4'b0000;
      exp_sel = 2'(m_owner);
      exp_valid = m_busy && req_valid[m_owner];
      exp_ready = (m_busy && mem_ready) ? (one << m_owner) : 4'b0000;
      checks++;
      if (grant !== exp_grant || busy !== m_busy || sel !== exp_sel) begin
        errors++;
        $display("FAIL random_grant c=%0d: grant=%b busy=%b sel=%0d, want %b %b %0d",
                 c, grant, busy, sel, exp_grant, m_busy, exp_sel);
      end
      checks++;
      if (mem_valid !== exp_valid || req_ready !== exp_ready) begin
        errors++;
        $display("FAIL random_handshake c=%0d: mem_valid=%b req_ready=%b, want %b %b",
                 c, mem_valid, req_ready, exp_valid, exp_ready);
      end
    end
    req_valid = 4'b0000;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid_burst();
`ifdef MEM_ARB_BURST_LOCK_EN
    test_lock_burst();
    test_lock_max_beats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
